// File: rtl/rf_wb_arbiter.sv
// Register-file write-port controller: clears x1..x31 after reset, then round-robins ALU/LSU writebacks.
// Latency: an accepted request appears on rf_wr_* one cycle later. Backpressure: the combinational ready goes to at most one requester.
module rf_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [4:0]            req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [4:0]            req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  rf_wr_en,
    output logic [4:0]            rf_wr_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    output logic                  init_done,
    output logic [CNT_WIDTH-1:0]  stall0_cnt,
    output logic [CNT_WIDTH-1:0]  stall1_cnt
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state_q, state_d;
    logic [4:0]            init_cnt_q, init_cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  wr_en_q, wr_en_d;
    logic [4:0]            wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  init_done_q, init_done_d;
    logic [CNT_WIDTH-1:0]  stall0_q, stall0_d;
    logic [CNT_WIDTH-1:0]  stall1_q, stall1_d;
    logic                  grant0, grant1;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == ST_RUN) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant_q;
                grant1 = ~last_grant_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        last_grant_d = last_grant_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        init_done_d  = init_done_q;
        stall0_d     = stall0_q;
        stall1_d     = stall1_q;

        if (state_q == ST_INIT) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = init_cnt_q;
            wr_data_d  = '0;
            init_cnt_d = init_cnt_q + 5'd1;
            if (init_cnt_q == 5'd31) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end else if (grant0) begin
            wr_en_d      = (req0_addr != 5'd0);
            wr_addr_d    = req0_addr;
            wr_data_d    = req0_data;
            last_grant_d = 1'b0;
        end else if (grant1) begin
            wr_en_d      = (req1_addr != 5'd0);
            wr_addr_d    = req1_addr;
            wr_data_d    = req1_data;
            last_grant_d = 1'b1;
        end

        // Counters stick at all-ones rather than wrapping.
        if (req0_valid && !grant0 && (stall0_q != '1))
            stall0_d = stall0_q + CNT_WIDTH'(1);
        if (req1_valid && !grant1 && (stall1_q != '1))
            stall1_d = stall1_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= 5'd1;
            last_grant_q <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 5'd0;
            wr_data_q    <= '0;
            init_done_q  <= 1'b0;
            stall0_q     <= '0;
            stall1_q     <= '0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            init_done_q  <= init_done_d;
            stall0_q     <= stall0_d;
            stall1_q     <= stall1_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rf_wr_en   = wr_en_q;
    assign rf_wr_addr = wr_addr_q;
    assign rf_wr_data = wr_data_q;
    assign init_done  = init_done_q;
    assign stall0_cnt = stall0_q;
    assign stall1_cnt = stall1_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: scenario tasks checked against a cycle-level reference model of the arbiter rules.
module tb_rf_wb_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic [4:0]    req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready, rf_wr_en, init_done;
    logic [4:0]    rf_wr_addr;
    logic [DW-1:0] rf_wr_data;
    logic [15:0]   stall0_cnt, stall1_cnt;

    logic          n_req0_ready, n_req1_ready, n_rf_wr_en, n_init_done;
    logic [4:0]    n_rf_wr_addr;
    logic [DW-1:0] n_rf_wr_data;
    logic [3:0]    n_stall0_cnt, n_stall1_cnt;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .init_done(init_done), .stall0_cnt(stall0_cnt), .stall1_cnt(stall1_cnt)
    );

    // Narrow-counter copy so that saturation is reachable in a short run.
    rf_wb_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) u_dut_narrow (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(n_req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(n_req1_ready),
        .rf_wr_en(n_rf_wr_en), .rf_wr_addr(n_rf_wr_addr), .rf_wr_data(n_rf_wr_data),
        .init_done(n_init_done), .stall0_cnt(n_stall0_cnt), .stall1_cnt(n_stall1_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit            m_init, m_done;
    int            m_next, m_lg, m_cnt0, m_cnt1;
    bit            exp_g0, exp_g1;
    logic          exp_en;
    logic [4:0]    exp_addr;
    logic [DW-1:0] exp_data;
    logic [DW-1:0] m_rf [32];
    logic [DW-1:0] d_rf [32];

    wire [38:0] dut_out    = {rf_wr_en, rf_wr_addr, rf_wr_data, init_done};
    wire [38:0] narrow_out = {n_rf_wr_en, n_rf_wr_addr, n_rf_wr_data, n_init_done};

    function automatic logic [38:0] exp_out();
        return {exp_en, exp_addr, exp_data, m_done};
    endfunction

    function automatic logic [15:0] sat16(input int c);
        return (c > 65535) ? 16'hFFFF : 16'(c);
    endfunction

    function automatic logic [3:0] sat4(input int c);
        return (c > 15) ? 4'hF : 4'(c);
    endfunction

    function automatic void model_grant();
        exp_g0 = 1'b0;
        exp_g1 = 1'b0;
        if (!m_init) begin
            if (req0_valid && req1_valid) begin
                if (m_lg == 1) exp_g0 = 1'b1;
                else           exp_g1 = 1'b1;
            end else begin
                exp_g0 = req0_valid;
                exp_g1 = req1_valid;
            end
        end
    endfunction

    task automatic drive(input bit v0, input logic [4:0] a0, input logic [DW-1:0] d0,
                         input bit v1, input logic [4:0] a1, input logic [DW-1:0] d1);
        @(negedge clk);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;
        model_grant();
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    endtask

    // Advance one clock edge and move the model through the same edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_init = 1; m_done = 0; m_next = 1; m_lg = 1; m_cnt0 = 0; m_cnt1 = 0;
            exp_en = 1'b0; exp_addr = 5'd0; exp_data = '0;
        end else begin
            if (req0_valid && !exp_g0) m_cnt0++;
            if (req1_valid && !exp_g1) m_cnt1++;
            if (m_init) begin
                exp_en = 1'b1; exp_addr = 5'(m_next); exp_data = '0;
                m_rf[m_next] = '0;
                if (m_next == 31) begin m_init = 0; m_done = 1; end
                m_next++;
            end else if (exp_g0 || exp_g1) begin
                exp_addr = exp_g0 ? req0_addr : req1_addr;
                exp_data = exp_g0 ? req0_data : req1_data;
                exp_en   = (exp_addr != 5'd0);
                if (exp_en) m_rf[exp_addr] = exp_data;
                m_lg = exp_g0 ? 0 : 1;
            end else begin
                exp_en = 1'b0;
            end
        end
        #1;
        if (rf_wr_en) d_rf[rf_wr_addr] = rf_wr_data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(); tick();
        idle(); tick();
        checks++;
        if (dut_out !== 39'd0) begin
            errors++; $display("FAIL reset_out got %h exp %h", dut_out, 39'd0);
        end
        checks++;
        if ({stall0_cnt, stall1_cnt, req0_ready, req1_ready} !== 34'd0) begin
            errors++; $display("FAIL reset_cnt got %h/%h rdy %b%b exp 0", stall0_cnt, stall1_cnt, req0_ready, req1_ready);
        end
    endtask

    task automatic test_mid_init_reset();
        reset = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            idle(); tick();
            checks++;
            if (dut_out !== exp_out() || rf_wr_addr !== 5'(i)) begin
                errors++; $display("FAIL init_seq%0d got %h exp %h", i, dut_out, exp_out());
            end
        end
        reset = 1'b1;
        idle(); tick();
        checks++;
        if (rf_wr_en !== 1'b0 || dut_out !== exp_out()) begin
            errors++; $display("FAIL midinit_reset got %h exp %h", dut_out, exp_out());
        end
        reset = 1'b0;
        idle(); tick();
        checks++;
        if (dut_out !== {1'b1, 5'd1, 32'd0, 1'b0}) begin
            errors++; $display("FAIL init_restart got %h exp addr 1", dut_out);
        end
        reset = 1'b1;
        idle(); tick();
        reset = 1'b0;
    endtask

    task automatic test_init();
        int bad_rdy = 0, bad_out = 0;
        for (int i = 1; i <= 31; i++) begin
            drive(1'b1, 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || exp_g0 || exp_g1) bad_rdy++;
            tick();
            if (dut_out !== exp_out() || rf_wr_addr !== 5'(i) || rf_wr_data !== '0) bad_out++;
        end
        checks++;
        if (bad_rdy != 0) begin errors++; $display("FAIL init_ready got %0d bad cycles exp 0", bad_rdy); end
        checks++;
        if (bad_out != 0) begin errors++; $display("FAIL init_writes got %0d bad cycles exp 0", bad_out); end
        checks++;
        if (init_done !== 1'b1) begin errors++; $display("FAIL init_done got %b exp 1", init_done); end
        checks++;
        if (stall0_cnt !== 16'd31 || stall1_cnt !== sat16(m_cnt1)) begin
            errors++; $display("FAIL init_stall got %0d/%0d exp 31/%0d", stall0_cnt, stall1_cnt, m_cnt1);
        end
        checks++;
        if (n_stall0_cnt !== 4'hF || n_stall1_cnt !== sat4(m_cnt1)) begin
            errors++; $display("FAIL stall_saturate got %h/%h exp f/%h", n_stall0_cnt, n_stall1_cnt, sat4(m_cnt1));
        end
    endtask

    task automatic test_single();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL single_ready got %b%b exp 10", req0_ready, req1_ready);
        end
        tick();
        checks++;
        if (dut_out !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b1}) begin
            errors++; $display("FAIL single_write got %h exp en addr5 deadbeef", dut_out);
        end
        idle(); tick();
        checks++;
        if (rf_wr_en !== 1'b0 || dut_out !== exp_out()) begin
            errors++; $display("FAIL single_idle got %h exp %h", dut_out, exp_out());
        end
    endtask

    task automatic test_x0();
        drive(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'h1234);
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++; $display("FAIL x0_ready got %b%b exp 01", req0_ready, req1_ready);
        end
        tick();
        checks++;
        if (rf_wr_en !== 1'b0 || dut_out !== exp_out()) begin
            errors++; $display("FAIL x0_nowrite got %h exp %h", dut_out, exp_out());
        end
    endtask

    // Runs after test_x0, so the last grant went to requester 1 and requester 0 wins first.
    task automatic test_both();
        int c0 = m_cnt0, c1 = m_cnt1;
        logic [3:0] seq = 4'b0;
        int bad_out = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd3, $urandom, 1'b1, 5'd4, $urandom);
            seq[3-i] = req1_ready;
            if (req0_ready === req1_ready) bad_out++;
            tick();
            if (dut_out !== exp_out()) bad_out++;
        end
        idle(); tick();
        checks++;
        if (seq !== 4'b0101) begin errors++; $display("FAIL both_grants got %b exp 0101 (1=req1)", seq); end
        checks++;
        if (bad_out != 0) begin errors++; $display("FAIL both_writes got %0d bad exp 0", bad_out); end
        checks++;
        if (stall0_cnt !== sat16(c0 + 2) || stall1_cnt !== sat16(c1 + 2)) begin
            errors++; $display("FAIL both_stall got %0d/%0d exp %0d/%0d", stall0_cnt, stall1_cnt, c0 + 2, c1 + 2);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'hAAAA0001);
        tick();
        checks++;
        if (dut_out !== {1'b1, 5'd7, 32'hAAAA0001, 1'b1}) begin
            errors++; $display("FAIL b2b_first got %h exp addr7 aaaa0001", dut_out);
        end
        drive(1'b1, 5'd7, 32'hBBBB0002, 1'b0, 5'd0, '0);
        tick();
        checks++;
        if (dut_out !== {1'b1, 5'd7, 32'hBBBB0002, 1'b1}) begin
            errors++; $display("FAIL b2b_second got %h exp addr7 bbbb0002", dut_out);
        end
        idle(); tick();
        checks++;
        if (d_rf[7] !== 32'hBBBB0002) begin
            errors++; $display("FAIL b2b_final got %h exp bbbb0002", d_rf[7]);
        end
    endtask

    task automatic test_random();
        bit p0 = 0, p1 = 0;
        logic [4:0] a0 = '0, a1 = '0;
        logic [DW-1:0] d0 = '0, d1 = '0;
        int bad_rdy = 0, bad_out = 0, bad_rf = 0;
        for (int i = 0; i < 400; i++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin p0 = 1; a0 = 5'($urandom); d0 = $urandom; end
            if (!p1 && $urandom_range(0, 2) != 0) begin p1 = 1; a1 = 5'($urandom); d1 = $urandom; end
            drive(p0, a0, d0, p1, a1, d1);
            if ({req0_ready, req1_ready} !== {exp_g0, exp_g1}) bad_rdy++;
            tick();
            if (dut_out !== exp_out() || narrow_out !== exp_out()) bad_out++;
            if (exp_g0) p0 = 0;
            if (exp_g1) p1 = 0;
        end
        idle(); tick();
        checks++;
        if (bad_rdy != 0) begin errors++; $display("FAIL rand_ready got %0d bad cycles exp 0", bad_rdy); end
        checks++;
        if (bad_out != 0) begin errors++; $display("FAIL rand_writes got %0d bad cycles exp 0", bad_out); end
        checks++;
        if (stall0_cnt !== sat16(m_cnt0) || stall1_cnt !== sat16(m_cnt1)) begin
            errors++; $display("FAIL rand_stall got %0d/%0d exp %0d/%0d", stall0_cnt, stall1_cnt, m_cnt0, m_cnt1);
        end
        checks++;
        if (n_stall0_cnt !== 4'hF || n_stall1_cnt !== sat4(m_cnt1)) begin
            errors++; $display("FAIL rand_narrow_stall got %h/%h exp f/%h", n_stall0_cnt, n_stall1_cnt, sat4(m_cnt1));
        end
        for (int r = 1; r < 32; r++) if (d_rf[r] !== m_rf[r]) bad_rf++;
        checks++;
        if (bad_rf != 0) begin errors++; $display("FAIL regfile_image got %0d wrong regs exp 0", bad_rf); end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin m_rf[r] = '1; d_rf[r] = '1; end
        reset = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        m_init = 1; m_done = 0; m_next = 1; m_lg = 1; m_cnt0 = 0; m_cnt1 = 0;
        exp_g0 = 0; exp_g1 = 0; exp_en = 0; exp_addr = '0; exp_data = '0;
        test_reset();
        test_mid_init_reset();
        test_init();
        test_single();
        test_x0();
        test_both();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
